// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the control unit and the 4-bit ALU: ALU opcodes,
// control opcodes and the sequencer state encoding.
package cpu_defs;

    localparam logic [2:0] TULA_ADD = 3'b000;
    localparam logic [2:0] TULA_SUB = 3'b001;
    localparam logic [2:0] TULA_NEG = 3'b010;
    localparam logic [2:0] TULA_EQ  = 3'b011;
    localparam logic [2:0] TULA_GT  = 3'b100;
    localparam logic [2:0] TULA_LT  = 3'b101;
    localparam logic [2:0] TULA_AND = 3'b110;
    localparam logic [2:0] TULA_XOR = 3'b111;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_BRT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Compares report through ula_stat; every other tula reports through ula_outp.
    function automatic logic is_compare(input logic [2:0] tula);
        return (tula == TULA_EQ) || (tula == TULA_GT) || (tula == TULA_LT);
    endfunction

endpackage

// File: rtl/banco_registradores.sv
// 4x4 register file: two combinational read ports, one synchronous write
// port, synchronous reset to zero.
module banco_registradores (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [3:0] wdata,
    input  logic [1:0] raddr_a,
    input  logic [1:0] raddr_b,
    output logic [3:0] rdata_a,
    output logic [3:0] rdata_b
);

    logic [3:0] regs [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/unidade_controle.sv
// Control-unit sequencer: fetches from a synchronous instruction memory,
// drives the ALU, and commits results to the register file and flag.
module unidade_controle
    import cpu_defs::*;
#(
    parameter int PC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [11:0]       imem_data,
    output logic signed [3:0] ula_a,
    output logic signed [3:0] ula_b,
    output logic [2:0]        ula_tula,
    input  logic signed [3:0] ula_outp,
    input  logic              ula_stat,
    output logic [3:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              halted,
    output state_t            dbg_state
);

    // Output port: out_valid is held with out_data stable until a cycle where
    // out_valid && out_ready; that edge is the transfer and advances pc.

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [11:0]     ir;
    logic            flag, flag_nxt;
    logic            rf_we;
    logic [3:0]      rf_wdata;
    logic [1:0]      ra_sel;
    logic [3:0]      rf_a, rf_b;
    logic [3:0]      ir_op;

    assign ir_op = ir[11:8];

    // In DECODE the operands come straight from the memory word; in EXEC the
    // OUT instruction reads its source through the latched ir.
    assign ra_sel = (state == ST_DECODE) ? imem_data[5:4] : ir[5:4];

    banco_registradores u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (ir[7:6]),
        .wdata   (rf_wdata),
        .raddr_a (ra_sel),
        .raddr_b (imem_data[3:2]),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        flag_nxt  = flag;
        rf_we     = 1'b0;
        rf_wdata  = ula_outp;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = '0;
                end
            end
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                pc_nxt    = pc + 1'b1;
                if (!ir_op[3]) begin
                    if (is_compare(ir_op[2:0])) begin
                        flag_nxt = ula_stat;
                    end else begin
                        rf_we    = 1'b1;
                        rf_wdata = ula_outp;
                    end
                end else begin
                    case (ir_op)
                        OP_LDI: begin
                            rf_we    = 1'b1;
                            rf_wdata = ir[3:0];
                        end
                        OP_BRT: if (flag) pc_nxt = ir[PC_W-1:0];
                        OP_JMP: pc_nxt = ir[PC_W-1:0];
                        OP_OUT: begin
                            out_valid = 1'b1;
                            if (!out_ready) begin
                                state_nxt = ST_EXEC;
                                pc_nxt    = pc;
                            end
                        end
                        OP_HALT: state_nxt = ST_HALTED;
                        default: ;
                    endcase
                end
            end
            ST_HALTED: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir       <= '0;
            flag     <= 1'b0;
            ula_a    <= '0;
            ula_b    <= '0;
            ula_tula <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            flag  <= flag_nxt;
            if (state == ST_DECODE) begin
                ir    <= imem_data;
                ula_a <= $signed(rf_a);
                ula_b <= $signed(rf_b);
                if (!imem_data[11]) begin
                    ula_tula <= imem_data[10:8];
                end
            end
        end
    end

    assign imem_addr = pc;
    assign out_data  = out_valid ? rf_a : 4'd0;
    assign busy      = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
    assign halted    = (state == ST_HALTED);
    assign dbg_state = state;

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Control-unit sequencer that acts as the initiator for the 4-bit ALU: it fetches 12-bit instructions from a synchronous instruction memory, decodes them, drives the ALU operand and `tula` opcode lines, and captures `outp`/`stat` into a register file and a status flag. It sits between instruction memory and the ALU at the top of the CPU datapath, and adds load-immediate, jumps, a conditional branch, an output port with a valid/ready handshake, and halt.

## Interface
- `PC_W`, default 4: program-counter width, legal range 1..8.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins execution at pc 0; sampled in IDLE or HALTED only.
- `imem_addr`  out  PC_W  equals pc combinationally.
- `imem_data`  in  12  instruction word, valid the cycle after the address is presented.
- `ula_a`, `ula_b`  out  4 (signed)  registered ALU operands.
- `ula_tula`  out  3  registered ALU opcode.
- `ula_outp`  in  4 (signed)  ALU result.
- `ula_stat`  in  1  ALU compare result.
- `out_data`  out  4  output-port data.
- `out_valid`  out  1  output-port valid.
- `out_ready`  in  1  output-port ready.
- `busy`  out  1  high in FETCH, DECODE and EXEC.
- `halted`  out  1  high in HALTED.

## Operation
- State: 4×4 register file r0..r3, pc, 1-bit `flag`, 12-bit `ir`.
- Instruction fields: op=[11:8], rd=[7:6], ra=[5:4], rb=[3:2], imm=[3:0], target=[PC_W-1:0].
- op 0xxx: ALU operation with tula=op[2:0].
  - tula 000, 001, 010, 110 and 111 write `ula_outp` to rd.
  - tula 011, 100 and 101 (eq, gt, lt) write `ula_stat` to `flag` and leave the registers unchanged.
  - `outp` is sampled only for the first group and `stat` only for compares, because the ALU holds stale values on its unused output.
- 1000 LDI: rd <= imm.
- 1001 BRT: pc <= flag ? target : pc+1.
- 1010 JMP: pc <= target.
- 1011 OUT: presents r[ra] on the output port.
- 1111 HALT.
- All other opcodes: NOP.
- Every instruction that does not load pc from target sets pc <= pc+1, modulo 2^PC_W.
- Arithmetic is 4-bit two's complement and wraps with no overflow flag. Example: 7+1 = 4'b1000 (-8).
- Only compare instructions modify `flag`.
- States and transitions:
  - IDLE: on `start` go to FETCH.
  - FETCH: go to DECODE.
  - DECODE: capture `ir <= imem_data`. Load ula_a <= r[ra], ula_b <= r[rb], ula_tula <= op[2:0] (when op[3]=0) from `imem_data`. Go to EXEC.
  - EXEC: commit the result and pc, then go to FETCH. HALT goes to HALTED instead. OUT stays in EXEC until the handshake completes.
  - HALTED: on `start` set pc <= 0 and go to FETCH. Registers and `flag` are retained.
- OUT handshake:
  - In EXEC, out_valid=1 and out_data=r[ra].
  - Transfer happens on the cycle where out_valid && out_ready. pc advances on that edge.
  - While waiting, out_data is stable and pc is unchanged.
  - out_valid is 0 in every other state.
- `start` is ignored while busy.
- rd=ra/rb aliasing is legal because operands are latched in DECODE.

## Timing
- Reset values: state IDLE; pc, all registers, flag, ir, ula_a, ula_b, ula_tula, out_data all 0; out_valid, busy, halted all 0.
- `start` high in IDLE at edge N puts FETCH at cycle N+1.
- Every instruction takes 3 cycles (FETCH, DECODE, EXEC). OUT adds one cycle per stall cycle with out_ready low.
- ALU result is captured at the end of EXEC, one full cycle after its operands are registered.
- pc wraps from 2^PC_W−1 to 0.
- `rst` overrides any state, including a pending OUT. The next cycle is IDLE with reset values.

## Structure
- Shared package `cpu_defs` holds:
  - ALU `tula` codes (ADD=000, SUB=001, NEG=010, EQ=011, GT=100, LT=101, AND=110, XOR=111), shared with the ALU.
  - Control opcodes: LDI, BRT, JMP, OUT, HALT.
  - FSM state encoding.
- Sub-module `banco_registradores`: 4×4 register file, two combinational read ports, one synchronous write port, synchronous reset to 0.

## Test plan
- Program 0x843, 0x885, 0x0D8, 0xB30, 0xF00 (r1=3, r2=5, r3=r1+r2, OUT r3, HALT), with out_ready=1 -> one out_valid pulse with out_data=8, then halted=1, busy=0.
- r1=7, r2=1, ADD into r3, OUT r3 -> out_data=4'b1000. SUB r1−r1 -> 0.
- r1=r2=4, EQ, then ADD, then BRT 6 -> branch taken, next imem_addr=6. With r2=5 -> not taken, pc+1. The intervening ADD leaves flag unchanged.
- OUT with out_ready low for 5 cycles -> out_valid held high, out_data stable, imem_addr unchanged. Next FETCH occurs the cycle after the ready edge.
- PC_W=4, NOP at address 15 -> next fetch at address 0.
- rst asserted while OUT is stalled -> next cycle IDLE, out_valid=0, pc=0, registers 0. A subsequent start refetches address 0.
